spin_ticker: RTL and testbench

//   Upstream step generator for the roulette display stage. A KEY press starts a spin: emits
//   1-cycle step pulses at a fixed fast rate, then at a steadily slowing rate until the wheel
//   "lands". Replaces the raw counter-bit tap as the roulette's advance strobe; also latches

---
 rtl/spin_ticker_if.sv | 29 ++
 rtl/spin_ticker.sv | 165 ++++++++++++++++
 tb/tb_spin_ticker.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/spin_ticker_if.sv
// spin_ticker_if: key input, direction request and step/status outputs of the
// roulette spin ticker. The master side is the top level (or a testbench) and
// the slave side is the ticker itself.
interface spin_ticker_if;
    logic key_n;
    logic dir_sw;
    logic step;
    logic dir;
    logic busy;
    logic landed;

    modport master (
        output key_n,
        output dir_sw,
        input  step,
        input  dir,
        input  busy,
        input  landed
    );

    modport slave (
        input  key_n,
        input  dir_sw,
        output step,
        output dir,
        output busy,
        output landed
    );
endinterface

// File: rtl/spin_ticker.sv
// spin_ticker: step generator for the roulette display stage.
// A key press starts a spin. Steps come at a fixed fast rate while spinning,
// then at a steadily slowing rate until the wheel lands.
// Optional feature: define SPIN_DEBOUNCE_EN to put a debouncer between the
// key synchroniser and the press edge detector (DB_CYCLES sets its stable time).
module spin_ticker #(
    parameter logic [31:0] BASE_DIV   = 32'd2_500_000,
    parameter logic [31:0] DECEL_STEP = 32'd250_000,
    parameter logic [31:0] MAX_DIV    = 32'd25_000_000,
    parameter logic [7:0]  SPIN_STEPS = 8'd24,
    parameter logic [31:0] DB_CYCLES  = 32'd1_000_000
) (
    input  logic           clk,
    input  logic           nrst,
    spin_ticker_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        DECEL,
        LAND
    } state_t;

    state_t      state;
    logic [31:0] per;
    logic [31:0] div;
    logic [7:0]  scnt;

    logic        key_sync1;
    logic        key_sync2;
    logic        key_lvl;
    logic        key_prev;
    logic        press;

    logic        div_hit;
    logic [32:0] per_sum;
    logic [31:0] per_inc;
    logic [7:0]  scnt_inc;

    // Two-stage synchroniser for the asynchronous key; idles at the released level
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            key_sync1 <= 1'b1;
            key_sync2 <= 1'b1;
        end else begin
            key_sync1 <= bus.key_n;
            key_sync2 <= key_sync1;
        end
    end

`ifdef SPIN_DEBOUNCE_EN
    logic [31:0] db_cnt;
    logic        key_filt;

    // Accept a new key level only after it has held steady for DB_CYCLES+1 cycles
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            key_filt <= 1'b1;
            db_cnt   <= '0;
        end else if (key_sync2 == key_filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_CYCLES) begin
            key_filt <= key_sync2;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 32'd1;
        end
    end

    assign key_lvl = key_filt;
`else
    logic unused_db;
    assign unused_db = ^DB_CYCLES;
    assign key_lvl   = key_sync2;
`endif

    // Remember the previous key level so a high-to-low edge gives a one-cycle press
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            key_prev <= 1'b1;
        end else begin
            key_prev <= key_lvl;
        end
    end

    assign press    = key_prev & ~key_lvl;
    assign div_hit  = (div == per - 32'd1);
    assign per_sum  = {1'b0, per} + {1'b0, DECEL_STEP};
    assign per_inc  = per_sum[32] ? 32'hFFFF_FFFF : per_sum[31:0];
    assign scnt_inc = (scnt == 8'hFF) ? scnt : scnt + 8'd1;

    // Spin state machine with registered step/dir/busy/landed outputs.
    // A press loads div with 1 because the press cycle itself is the first
    // cycle of the opening period, so the first step lands BASE_DIV cycles later.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            per        <= '0;
            div        <= '0;
            scnt       <= '0;
            bus.step   <= 1'b0;
            bus.dir    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.landed <= 1'b0;
        end else begin
            bus.step   <= 1'b0;
            bus.landed <= 1'b0;
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    if (press) begin
                        bus.dir  <= bus.dir_sw;
                        bus.busy <= 1'b1;
                        per      <= BASE_DIV;
                        div      <= 32'd1;
                        scnt     <= '0;
                        state    <= SPIN;
                    end
                end
                SPIN: begin
                    if (div_hit) begin
                        bus.step <= 1'b1;
                        div      <= '0;
                        scnt     <= scnt_inc;
                        if (scnt_inc >= SPIN_STEPS && key_lvl) begin
                            per   <= per_inc;
                            state <= DECEL;
                        end
                    end else begin
                        div <= div + 32'd1;
                    end
                end
                DECEL: begin
                    if (press) begin
                        bus.dir <= bus.dir_sw;
                        per     <= BASE_DIV;
                        div     <= 32'd1;
                        scnt    <= '0;
                        state   <= SPIN;
                    end else if (div_hit) begin
                        bus.step <= 1'b1;
                        div      <= '0;
                        scnt     <= scnt_inc;
                        per      <= per_inc;
                        if (per_inc > MAX_DIV) begin
                            state <= LAND;
                        end
                    end else begin
                        div <= div + 32'd1;
                    end
                end
                LAND: begin
                    bus.landed <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spin_ticker.sv
// tb_spin_ticker: self-checking bench for spin_ticker with small divider values.
// Expected step and landed cycles are queued when a press is driven and popped
// by a monitor as the DUT produces them.
module tb_spin_ticker;

`ifdef SPIN_DEBOUNCE_EN
    localparam int PRESS_LAT = 7;
`else
    localparam int PRESS_LAT = 2;
`endif

    typedef struct {
        string name;
        int    low_cycles;
        bit    dir_in;
        int    n_steps;
        int    offs[16];
        int    land_off;
    } vec_t;

    logic clk;
    logic nrst;
    int   cycle;
    int   total;
    int   passes;
    int   exp_steps[$];
    int   exp_land[$];

    spin_ticker_if bus_if ();

    spin_ticker #(
        .BASE_DIV   (32'd4),
        .DECEL_STEP (32'd2),
        .MAX_DIV    (32'd10),
        .SPIN_STEPS (8'd3),
        .DB_CYCLES  (32'd4)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle = cycle + 1;

    function automatic void checkOutput(string name, int actual, int expected);
        total = total + 1;
        if (actual == expected) begin
            passes = passes + 1;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endfunction

    // Scoreboard monitor: every step/landed pulse must match the next queued cycle
    always @(negedge clk) begin
        if (bus_if.step === 1'b1) begin
            if (exp_steps.size() == 0) checkOutput("step_unexpected", cycle, -1);
            else checkOutput("step_cycle", cycle, exp_steps.pop_front());
        end
        if (bus_if.landed === 1'b1) begin
            if (exp_land.size() == 0) checkOutput("landed_unexpected", cycle, -1);
            else checkOutput("landed_cycle", cycle, exp_land.pop_front());
        end
    end

    task automatic waitUntil(input int c);
        while (cycle < c) @(negedge clk);
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_steps_left"}, exp_steps.size(), 0);
        checkOutput({tag, "_land_left"}, exp_land.size(), 0);
    endtask

    // One full spin from a single press; dir_sw is flipped mid-spin to prove it is latched
    task automatic applyStimulus(input vec_t v);
        int p;
        int t;
        @(negedge clk);
        p = cycle;
        t = p + PRESS_LAT;
        for (int i = 0; i < v.n_steps; i++) exp_steps.push_back(t + v.offs[i]);
        exp_land.push_back(t + v.land_off);
        bus_if.dir_sw = v.dir_in;
        bus_if.key_n  = 1'b0;
        while (cycle < t + v.land_off + 3) begin
            @(negedge clk);
            if (cycle == p + v.low_cycles) bus_if.key_n = 1'b1;
            if (cycle == t + 10) bus_if.dir_sw = ~v.dir_in;
            if (cycle == t) checkOutput({v.name, "_busy_press"}, bus_if.busy, 0);
            if (cycle == t + 1) begin
                checkOutput({v.name, "_busy_start"}, bus_if.busy, 1);
                checkOutput({v.name, "_dir_start"}, bus_if.dir, v.dir_in);
            end
            if (cycle == t + v.land_off - 1) begin
                checkOutput({v.name, "_busy_last"}, bus_if.busy, 1);
                checkOutput({v.name, "_dir_last"}, bus_if.dir, v.dir_in);
            end
            if (cycle == t + v.land_off) checkOutput({v.name, "_busy_landed"}, bus_if.busy, 0);
        end
        checkDrained(v.name);
    endtask

    vec_t vecs[3];

    initial begin
        int p;
        int t;
        int t2;

        total  = 0;
        passes = 0;

        vecs[0].name = "tap_dir1";  vecs[0].low_cycles = 3;  vecs[0].dir_in = 1'b1;
        vecs[0].n_steps = 6;  vecs[0].land_off = 37;
        vecs[0].offs = '{4, 8, 12, 18, 26, 36, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1].name = "hold_dir0"; vecs[1].low_cycles = 40; vecs[1].dir_in = 1'b0;
        vecs[1].n_steps = 14; vecs[1].land_off = 69;
        vecs[1].offs = '{4, 8, 12, 16, 20, 24, 28, 32, 36, 40, 44, 50, 58, 68, 0, 0};
        vecs[2].name = "tap_dir0";  vecs[2].low_cycles = 3;  vecs[2].dir_in = 1'b0;
        vecs[2].n_steps = 6;  vecs[2].land_off = 37;
        vecs[2].offs = '{4, 8, 12, 18, 26, 36, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef SPIN_DEBOUNCE_EN
        vecs[0].low_cycles = 10;
        vecs[2].low_cycles = 10;
`endif

        nrst          = 1'b0;
        bus_if.key_n  = 1'b1;
        bus_if.dir_sw = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_step", bus_if.step, 0);
        checkOutput("reset_dir", bus_if.dir, 0);
        checkOutput("reset_busy", bus_if.busy, 0);
        checkOutput("reset_landed", bus_if.landed, 0);
        nrst = 1'b1;
        repeat (5) @(negedge clk);

`ifdef SPIN_DEBOUNCE_EN
        $display("[TB] debounce build: short glitch must be filtered");
        bus_if.key_n = 1'b0;
        repeat (2) @(negedge clk);
        bus_if.key_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("glitch_busy", bus_if.busy, 0);
        checkDrained("glitch");
        applyStimulus(vecs[0]);
        repeat (5) @(negedge clk);
`else
        $display("[TB] table-driven spins");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i]);
            repeat (5) @(negedge clk);
        end

        $display("[TB] re-kick during deceleration");
        @(negedge clk);
        p = cycle;
        t = p + PRESS_LAT;
        t2 = t + 20;
        exp_steps.push_back(t + 4);
        exp_steps.push_back(t + 8);
        exp_steps.push_back(t + 12);
        exp_steps.push_back(t + 18);
        exp_steps.push_back(t2 + 4);
        exp_steps.push_back(t2 + 8);
        exp_steps.push_back(t2 + 12);
        exp_steps.push_back(t2 + 18);
        exp_steps.push_back(t2 + 26);
        exp_steps.push_back(t2 + 36);
        exp_land.push_back(t2 + 37);
        bus_if.dir_sw = 1'b0;
        bus_if.key_n  = 1'b0;
        waitUntil(p + 3);
        bus_if.key_n = 1'b1;
        waitUntil(t + 18);
        bus_if.dir_sw = 1'b1;
        bus_if.key_n  = 1'b0;
        waitUntil(t + 21);
        bus_if.key_n = 1'b1;
        checkOutput("rekick_busy", bus_if.busy, 1);
        checkOutput("rekick_dir", bus_if.dir, 1);
        waitUntil(t2 + 37);
        checkOutput("rekick_busy_landed", bus_if.busy, 0);
        repeat (3) @(negedge clk);
        checkDrained("rekick");

        $display("[TB] asynchronous reset mid-spin");
        @(negedge clk);
        p = cycle;
        t = p + PRESS_LAT;
        exp_steps.push_back(t + 4);
        exp_steps.push_back(t + 8);
        bus_if.dir_sw = 1'b1;
        bus_if.key_n  = 1'b0;
        waitUntil(p + 3);
        bus_if.key_n = 1'b1;
        waitUntil(t + 9);
        checkOutput("abort_busy_before", bus_if.busy, 1);
        checkOutput("abort_dir_before", bus_if.dir, 1);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        checkOutput("abort_step", bus_if.step, 0);
        checkOutput("abort_busy", bus_if.busy, 0);
        checkOutput("abort_landed", bus_if.landed, 0);
        checkOutput("abort_dir", bus_if.dir, 0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("abort_busy_after", bus_if.busy, 0);
        checkDrained("abort");
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
